// File: rtl/data_mem_sequencer.sv
// data_mem_sequencer: round-robin word access to a byte-wide memory, split into four little-endian byte beats.
module data_mem_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              ready0,
  output logic              ready1,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_w_en,
  output logic              mem_r_en,
  input  logic [7:0]        mem_rdata
);
  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, BEAT2, BEAT3, DONE} state_t;
  state_t            state_q;
  logic              prio_q;
  logic              owner_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic              gnt;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [31:0]       g_wdata;
  logic [1:0]        k;
  assign gnt     = req1 & (~req0 | prio_q);
  assign g_we    = gnt ? we1 : we0;
  assign g_addr  = gnt ? addr1 : addr0;
  assign g_wdata = gnt ? wdata1 : wdata0;
  // The base is word aligned, so the low address bits double as the beat index.
  assign k = mem_addr[1:0] + 2'd1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      ready0    <= 1'b0;
      ready1    <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_w_en  <= 1'b0;
      mem_r_en  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req0 | req1) begin
          owner_q   <= gnt;
          prio_q    <= ~gnt;
          we_q      <= g_we;
          wdata_q   <= g_wdata;
          mem_addr  <= g_addr & ~ADDR_W'(3);
          mem_wdata <= g_wdata[7:0];
          mem_w_en  <= g_we;
          mem_r_en  <= ~g_we;
          state_q   <= BEAT0;
        end
        BEAT0, BEAT1, BEAT2, BEAT3: begin
          if (!we_q) rdata[{mem_addr[1:0], 3'b000} +: 8] <= mem_rdata;
          if (state_q == BEAT3) begin
            mem_w_en <= 1'b0;
            mem_r_en <= 1'b0;
            ready0   <= ~owner_q;
            ready1   <= owner_q;
            state_q  <= DONE;
          end else begin
            mem_addr  <= {mem_addr[ADDR_W-1:2], k};
            mem_wdata <= wdata_q[{k, 3'b000} +: 8];
            state_q   <= state_t'(state_q + 3'd1);
          end
        end
        default: begin
          ready0  <= 1'b0;
          ready1  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/data_mem_sequencer.md
# data_mem_sequencer

Word-access controller in front of the byte-wide data memory (`Data_Memory`: 8-bit cells, combinational read, write on posedge). It shares the memory between two 32-bit requesters (port 0: pipeline MEM stage; port 1: loader/debug port) with round-robin arbitration. Each granted word access is split into four byte beats, little-endian. A one-cycle `ready` pulse tells the owning requester to release its pipeline freeze.

## Interface
- `ADDR_W`, 32, byte-address width on both the requester side and the memory side.
- `clk` input 1: single clock, all state updates on posedge.
- `rst` input 1: asynchronous, active-high reset.
- `req0` / `req1` input 1: access request from requester 0 / 1. Held high until that port's `ready`.
- `we0` / `we1` input 1: 1 = store word, 0 = load word. Held stable with `req`.
- `addr0` / `addr1` input `ADDR_W`: byte address. Bits [1:0] are ignored (word aligned).
- `wdata0` / `wdata1` input 32: store data.
- `ready0` / `ready1` output 1: one-cycle completion pulse to the owning port.
- `rdata` output 32: assembled load word. Shared by both ports; valid while the owner's `ready` is high.
- `mem_addr` output `ADDR_W`: byte address to memory.
- `mem_wdata` output 8: byte to write.
- `mem_w_en` output 1: memory write enable.
- `mem_r_en` output 1: memory read enable.
- `mem_rdata` input 8: combinational byte read from memory.

## Operation
- States: IDLE, BEAT0, BEAT1, BEAT2, BEAT3, DONE.
- IDLE:
  - If any `req` is high, choose the owner, latch `we`, `{addr[ADDR_W-1:2],2'b00}` and `wdata` from the owner, then go to BEAT0.
  - With no request, stay in IDLE.
- Arbitration is round-robin:
  - The `prio` register resets to 0 (port 0 favoured).
  - When only one port requests, it is granted.
  - When both request, port `prio` is granted.
  - On every grant, `prio` becomes the index of the port that was not granted.
- BEATk (k = 0..3):
  - `mem_addr` = latched base + k.
  - Store: `mem_w_en` = 1, `mem_wdata` = wdata[8k+7:8k].
  - Load: `mem_r_en` = 1, and `mem_rdata` is captured into `rdata[8k+7:8k]` at the end of the beat.
  - BEATk advances to BEAT(k+1); BEAT3 advances to DONE.
- DONE:
  - `ready` of the owner = 1 for exactly this cycle.
  - For a load, `rdata` holds the full word. For a store, `rdata` keeps its previous value.
  - Next state is IDLE.
- Outside the BEAT states: `mem_w_en` = `mem_r_en` = 0, `mem_addr` and `mem_wdata` hold their last values.
- Inputs from the non-owner, and owner input changes after the grant, are ignored until IDLE.
- Reset values:
  - State IDLE, `prio` 0.
  - `ready0` = `ready1` = 0, `rdata` = 0.
  - `mem_addr` = 0, `mem_wdata` = 0, `mem_w_en` = `mem_r_en` = 0.
- Reset mid-access:
  - The access is aborted immediately. No further beats occur and no `ready` is issued.
  - Bytes already written stay in memory (partial store).
- Address wrap: base + k is computed on the full `ADDR_W` bits. The base is aligned, so the word never crosses a word boundary.

## Timing
- Request seen high in IDLE at cycle t:
  - Beats occur in cycles t+1 to t+4.
  - `ready` is high in cycle t+5.
  - The FSM is back in IDLE in cycle t+6.
- Latency: 5 cycles from grant to `ready`. Throughput: one word per 6 cycles.
- Requesters must hold `req`, `we`, `addr` and `wdata` through the `ready` cycle. A new request may be presented from the next cycle.
- Per-port `req` sampled in IDLE at t+6 is treated as a fresh request.
- `mem_*` outputs are registered and change only on `clk`. The memory write for beat k occurs on the posedge ending that beat.

## Test plan
- Load from 100 with memory preloaded {100:0xFF, 101:0x00, 102:0x01, 103:0x00}, `req0` only -> 4 read beats at addresses 100..103, `ready0` at t+5, `rdata` = 0x000100FF.
- Store 0xDEADBEEF to 200 via port 1, then load 200 via port 0 -> bytes 200..203 = EF, BE, AD, DE; load returns 0xDEADBEEF.
- `req0` and `req1` held continuously from reset -> grants alternate 0, 1, 0, 1; each `ready` is a single-cycle pulse, 6 cycles apart.
- Unaligned load from `addr0` = 103 -> `mem_addr` sequence 100, 101, 102, 103; returns 0x000100FF.
- Store 0x11223344 to 300, `rst` pulsed during BEAT2 -> bytes 300 = 44 and 301 = 33 are written, 302..303 are unchanged, no `ready`, and all outputs read their reset values while `rst` is high.
- Port 1 requests while port 0 is mid-access -> port 1 is granted in the IDLE cycle after port 0's `ready`; port 0's later `req` waits if it arrives after port 1's grant.
